// File: rtl/mips_pkg.sv
// Opcode constants and decode helpers shared by the 16-bit MIPS-style core
// (ALU controller, memory stage and anything else that classifies ins[15:12]).
package mips_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_RTYPE = 4'b0000;
    localparam opcode_t OP_LW    = 4'b1000;
    localparam opcode_t OP_BEQ   = 4'b1001;
    localparam opcode_t OP_BNE   = 4'b1010;
    localparam opcode_t OP_SW    = 4'b1011;
    localparam opcode_t OP_BR3   = 4'b1100;

    // R-type, every ALU-immediate (0001..0111) and LW write the register file.
    function automatic logic writes_reg(input opcode_t op);
        return (op == OP_RTYPE) || (op < OP_LW) || (op == OP_LW);
    endfunction

    function automatic logic is_branch(input opcode_t op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BR3);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: DEPTH x 16 words, combinational read, synchronous gated write.
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, branch redirect, data-memory access,
// MEM/WB register and the EX/MEM forwarding tap.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] result_ex,
    input  logic [15:0] write_data_ex,
    input  logic [15:0] ins_ex,
    input  logic [2:0]  wba_ex,
    input  logic        do_branch_ex,
    input  logic [15:0] branch_addr_ex,
    output logic        branch_taken,
    output logic [15:0] branch_target,
    output logic        fwd_valid,
    output logic [2:0]  fwd_addr,
    output logic [15:0] fwd_data,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [15:0] ins_wb
);

    logic        ex_valid_reg;
    logic [15:0] ex_result_reg;
    logic [15:0] ex_wdata_reg;
    logic [15:0] ex_ins_reg;
    logic [2:0]  ex_wba_reg;
    logic        ex_dob_reg;
    logic [15:0] ex_baddr_reg;

    logic        wb_en_reg;
    logic [2:0]  wb_addr_reg;
    logic [15:0] wb_data_reg;
    logic [15:0] ins_wb_reg;

    opcode_t            ex_op;
    logic               ex_is_lw;
    logic               ex_is_sw;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_index;
    logic [15:0]        mem_rdata;
    logic               wb_en_next;
    logic [15:0]        wb_data_next;

    // A flushed slot only clears valid; the payload is don't-care and simply held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg  <= 1'b0;
            ex_result_reg <= '0;
            ex_wdata_reg  <= '0;
            ex_ins_reg    <= '0;
            ex_wba_reg    <= '0;
            ex_dob_reg    <= 1'b0;
            ex_baddr_reg  <= '0;
        end else if (flush) begin
            ex_valid_reg  <= 1'b0;
        end else if (!stall) begin
            ex_valid_reg  <= 1'b1;
            ex_result_reg <= result_ex;
            ex_wdata_reg  <= write_data_ex;
            ex_ins_reg    <= ins_ex;
            ex_wba_reg    <= wba_ex;
            ex_dob_reg    <= do_branch_ex;
            ex_baddr_reg  <= branch_addr_ex;
        end
    end

    assign ex_op     = ex_ins_reg[15:12];
    assign ex_is_lw  = (ex_op == OP_LW);
    assign ex_is_sw  = (ex_op == OP_SW);
    assign mem_index = ex_result_reg[ADDR_W:1];

    // Reset clears ex_valid_reg asynchronously, so a store caught by reset never writes.
    assign mem_we = ex_valid_reg && ex_is_sw && !stall;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_index),
        .wdata (ex_wdata_reg),
        .rdata (mem_rdata)
    );

    assign wb_en_next   = ex_valid_reg && writes_reg(ex_op);
    assign wb_data_next = ex_is_lw ? mem_rdata : ex_result_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
            ins_wb_reg  <= '0;
        end else if (!stall) begin
            wb_en_reg   <= wb_en_next;
            wb_addr_reg <= ex_wba_reg;
            wb_data_reg <= wb_data_next;
            ins_wb_reg  <= ex_ins_reg;
        end
    end

    assign branch_taken  = ex_valid_reg && ex_dob_reg && is_branch(ex_op);
    assign branch_target = ex_baddr_reg;

    // Loads are excluded from forwarding: their data is not known until MEM/WB.
    assign fwd_valid = ex_valid_reg && writes_reg(ex_op) && !ex_is_lw;
    assign fwd_addr  = ex_wba_reg;
    assign fwd_data  = ex_result_reg;

    assign wb_en   = wb_en_reg;
    assign wb_addr = wb_addr_reg;
    assign wb_data = wb_data_reg;
    assign ins_wb  = ins_wb_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic,
// all compared each cycle against an instruction-level reference model.
module tb_mem_stage;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] result_ex = '0;
    logic [15:0] write_data_ex = '0;
    logic [15:0] ins_ex = '0;
    logic [2:0]  wba_ex = '0;
    logic        do_branch_ex = 1'b0;
    logic [15:0] branch_addr_ex = '0;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] ins_wb;

    mem_stage #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .result_ex      (result_ex),
        .write_data_ex  (write_data_ex),
        .ins_ex         (ins_ex),
        .wba_ex         (wba_ex),
        .do_branch_ex   (do_branch_ex),
        .branch_addr_ex (branch_addr_ex),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .ins_wb         (ins_wb)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction sitting in the stage, the pending write-back, memory.
    typedef struct {
        bit        valid;
        bit [15:0] result;
        bit [15:0] wdata;
        bit [15:0] ins;
        bit [2:0]  wba;
        bit        dob;
        bit [15:0] baddr;
    } instr_t;

    instr_t    m_ex;
    bit        m_wb_en;
    bit [2:0]  m_wb_addr;
    bit [15:0] m_wb_data;
    bit [15:0] m_wb_ins;
    bit [15:0] m_mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    localparam bit [15:0] NOP = 16'hD000;

    function automatic bit writes(input bit [3:0] op);
        return op <= 4'd8;
    endfunction

    function automatic bit is_br(input bit [3:0] op);
        return (op == 4'd9) || (op == 4'd10) || (op == 4'd12);
    endfunction

    function automatic int widx(input bit [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        bit [3:0] op;
        bit exp_bt;
        bit exp_fv;
        op = m_ex.ins[15:12];
        exp_bt = m_ex.valid && m_ex.dob && is_br(op);
        exp_fv = m_ex.valid && writes(op) && (op != 4'd8);
        chk("branch_taken", 16'(branch_taken), 16'(exp_bt));
        chk("fwd_valid", 16'(fwd_valid), 16'(exp_fv));
        chk("wb_en", 16'(wb_en), 16'(m_wb_en));
        if (!rst_n || m_ex.valid) begin
            chk("branch_target", branch_target, m_ex.baddr);
            chk("fwd_addr", 16'(fwd_addr), 16'(m_ex.wba));
            chk("fwd_data", fwd_data, m_ex.result);
        end
        if (!rst_n || m_wb_en) begin
            chk("wb_addr", 16'(wb_addr), 16'(m_wb_addr));
            chk("wb_data", wb_data, m_wb_data);
            chk("ins_wb", ins_wb, m_wb_ins);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        instr_t    old;
        bit [3:0]  op;
        @(posedge clk);
        cyc++;
        old = m_ex;
        op  = old.ins[15:12];
        if (!rst_n) begin
            m_ex      = '{default: 0};
            m_wb_en   = 1'b0;
            m_wb_addr = '0;
            m_wb_data = '0;
            m_wb_ins  = '0;
        end else begin
            if (!stall) begin
                m_wb_en   = old.valid && writes(op);
                m_wb_addr = old.wba;
                m_wb_data = (op == 4'd8) ? m_mem[widx(old.result)] : old.result;
                m_wb_ins  = old.ins;
                if (old.valid && op == 4'd11) m_mem[widx(old.result)] = old.wdata;
            end
            if (flush) begin
                m_ex.valid = 1'b0;
            end else if (!stall) begin
                m_ex = '{valid: 1'b1, result: result_ex, wdata: write_data_ex, ins: ins_ex,
                         wba: wba_ex, dob: do_branch_ex, baddr: branch_addr_ex};
            end
        end
        #1;
        $display("cyc %0d rst_n=%b stall=%b flush=%b ins_ex=%h res=%h | bt=%b fwd=%b/%0d/%h wb=%b/%0d/%h",
                 cyc, rst_n, stall, flush, ins_ex, result_ex, branch_taken,
                 fwd_valid, fwd_addr, fwd_data, wb_en, wb_addr, wb_data);
        check_all();
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] res, input logic [15:0] wd,
                         input logic [2:0] wba, input logic dob, input logic [15:0] ba);
        ins_ex         = ins;
        result_ex      = res;
        write_data_ex  = wd;
        wba_ex         = wba;
        do_branch_ex   = dob;
        branch_addr_ex = ba;
    endtask

    task automatic drive_nop();
        drive(NOP, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 16'($urandom));
    endtask

    initial begin
        bit [3:0] ops [11];
        ops = '{4'd0, 4'd3, 4'd7, 4'd8, 4'd8, 4'd9, 4'd10, 4'd11, 4'd11, 4'd12, 4'd13};

        // Reset with random inputs on the bus.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'b1, 16'($urandom));
            cycle();
        end
        rst_n = 1'b1;

        // Give every word a known value so later random loads are predictable.
        for (int i = 0; i < DEPTH; i++) begin
            drive({4'hB, 12'($urandom)}, 16'(i * 2), 16'($urandom), 3'($urandom), 1'b0, 16'($urandom));
            cycle();
        end
        drive_nop(); cycle();

        // Store then dependent load, two edges to write-back.
        drive(16'hB123, 16'h0006, 16'hBEEF, 3'd0, 1'b0, 16'h0000); cycle();
        drive(16'h8456, 16'h0006, 16'h0000, 3'd3, 1'b0, 16'h0000); cycle();
        chk("sw_wb_en", 16'(wb_en), 16'd0);
        drive_nop(); cycle();
        chk("lw_wb_en", 16'(wb_en), 16'd1);
        chk("lw_wb_addr", 16'(wb_addr), 16'd3);
        chk("lw_wb_data", wb_data, 16'hBEEF);

        // R-type forwarding tap then write-back.
        drive(16'h0123, 16'h1234, 16'h0000, 3'd5, 1'b0, 16'h0000); cycle();
        chk("rt_fwd_valid", 16'(fwd_valid), 16'd1);
        chk("rt_fwd_addr", 16'(fwd_addr), 16'd5);
        chk("rt_fwd_data", fwd_data, 16'h1234);
        drive_nop(); cycle();
        chk("rt_wb_en", 16'(wb_en), 16'd1);
        chk("rt_wb_data", wb_data, 16'h1234);

        // Taken and not-taken branch.
        drive(16'h9000, 16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0040); cycle();
        chk("br_taken", 16'(branch_taken), 16'd1);
        chk("br_target", branch_target, 16'h0040);
        drive_nop(); cycle();
        chk("br_one_cycle", 16'(branch_taken), 16'd0);
        drive(16'h9000, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0040); cycle();
        chk("br_not_taken", 16'(branch_taken), 16'd0);

        // Store held by a three-cycle stall.
        drive(16'hB000, 16'h0010, 16'hCAFE, 3'd0, 1'b0, 16'h0000); cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(16'h0777, 16'($urandom), 16'($urandom), 3'd1, 1'b1, 16'($urandom));
            cycle();
            chk("stall_fwd_valid", 16'(fwd_valid), 16'd0);
        end
        stall = 1'b0;
        drive(16'h8000, 16'h0010, 16'h0000, 3'd2, 1'b0, 16'h0000); cycle();
        drive_nop(); cycle();
        chk("stall_lw_data", wb_data, 16'hCAFE);

        // Flush together with stall inserts a bubble.
        drive(16'h0001, 16'h5555, 16'h0000, 3'd6, 1'b0, 16'h0000); cycle();
        stall = 1'b1; flush = 1'b1;
        drive(16'h0002, 16'h6666, 16'h0000, 3'd7, 1'b0, 16'h0000); cycle();
        stall = 1'b0; flush = 1'b0;
        drive_nop(); cycle();
        chk("flush_bubble_wb_en", 16'(wb_en), 16'd0);

        // Address wrap and ignored bit 0.
        drive(16'hB000, 16'h0202, 16'h7A7A, 3'd0, 1'b0, 16'h0000); cycle();
        drive(16'h8000, 16'h0002, 16'h0000, 3'd1, 1'b0, 16'h0000); cycle();
        drive(16'h8000, 16'h0003, 16'h0000, 3'd4, 1'b0, 16'h0000); cycle();
        chk("wrap_lw_data", wb_data, 16'h7A7A);
        drive_nop(); cycle();
        chk("odd_lw_addr", 16'(wb_addr), 16'd4);
        chk("odd_lw_data", wb_data, 16'h7A7A);

        // Reset arriving while a store occupies the stage aborts the write.
        drive(16'hB000, 16'h0020, 16'h1111, 3'd0, 1'b0, 16'h0000); cycle();
        drive(16'hB000, 16'h0020, 16'h2222, 3'd0, 1'b0, 16'h0000); cycle();
        rst_n = 1'b0;
        drive_nop(); cycle();
        rst_n = 1'b1;
        drive(16'h8000, 16'h0020, 16'h0000, 3'd2, 1'b0, 16'h0000); cycle();
        drive_nop(); cycle();
        chk("rst_abort_data", wb_data, 16'h1111);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive({ops[$urandom_range(0, 10)], 12'($urandom)}, 16'($urandom), 16'($urandom),
                  3'($urandom), 1'($urandom), 16'($urandom));
            cycle();
        end
        stall = 1'b0; flush = 1'b0;
        drive_nop(); cycle();
        drive_nop(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
